// File: rtl/axil_pwm_slave.sv
`default_nettype none
// ============================================================================
//  Module   : axil_pwm_slave
//  Purpose  : AXI4-Lite register slave driving a prescaled, shadow-buffered PWM
//  Revision : 1.0 - initial release
// ============================================================================
module axil_pwm_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4,
    parameter int PWM_CNT_WIDTH      = 16
) (
    input  logic                            ACLK,
    input  logic                            ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic                            PWM_OUT,
    output logic                            PERIOD_TICK
);
    localparam int STRB_W = C_S_AXI_DATA_WIDTH / 8;
    localparam int CW     = PWM_CNT_WIDTH;

    logic [C_S_AXI_DATA_WIDTH-1:0] regs [4];
    logic                          awready, wready, bvalid, arready, rvalid;
    logic [C_S_AXI_DATA_WIDTH-1:0] rdata;
    logic                          write_accept, read_accept;
    logic [1:0]                    wsel, rsel;

    assign wsel         = S_AXI_AWADDR[3:2];
    assign rsel         = S_AXI_ARADDR[3:2];
    assign write_accept = S_AXI_AWVALID & S_AXI_WVALID & ~bvalid & ~awready;
    assign read_accept  = S_AXI_ARVALID & ~rvalid & ~arready;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            awready <= 1'b0;
            wready  <= 1'b0;
            bvalid  <= 1'b0;
            for (int r = 0; r < 4; r++) regs[r] <= '0;
        end else begin
            awready <= write_accept;
            wready  <= write_accept;
            if (write_accept) begin
                for (int b = 0; b < STRB_W; b++) begin
                    if (S_AXI_WSTRB[b]) regs[wsel][b*8 +: 8] <= S_AXI_WDATA[b*8 +: 8];
                end
            end
            if (awready)                    bvalid <= 1'b1;
            else if (bvalid && S_AXI_BREADY) bvalid <= 1'b0;
        end
    end

    // RDATA is sampled before any same-edge write lands, so it returns the old value
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            arready <= 1'b0;
            rvalid  <= 1'b0;
            rdata   <= '0;
        end else begin
            arready <= read_accept;
            if (read_accept) rdata <= regs[rsel];
            if (arready)                    rvalid <= 1'b1;
            else if (rvalid && S_AXI_RREADY) rvalid <= 1'b0;
        end
    end

    assign S_AXI_AWREADY = awready;
    assign S_AXI_WREADY  = wready;
    assign S_AXI_BVALID  = bvalid;
    assign S_AXI_BRESP   = 2'b00;
    assign S_AXI_ARREADY = arready;
    assign S_AXI_RVALID  = rvalid;
    assign S_AXI_RDATA   = rdata;
    assign S_AXI_RRESP   = 2'b00;

    logic          en, pol, tick, wrap;
    logic [CW-1:0] period, duty, prescale;
    logic [CW-1:0] pcnt, cnt, act_period, act_duty;

    assign en       = regs[0][0];
    assign pol      = regs[0][1];
    assign period   = regs[1][CW-1:0];
    assign duty     = regs[2][CW-1:0];
    assign prescale = regs[3][CW-1:0];
    assign tick     = (pcnt == prescale);
    assign wrap     = tick && (cnt == act_period);

    // Shadows track the registers while idle and only reload on a wrap when running
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            pcnt        <= '0;
            cnt         <= '0;
            act_period  <= '0;
            act_duty    <= '0;
            PWM_OUT     <= 1'b0;
            PERIOD_TICK <= 1'b0;
        end else if (!en) begin
            pcnt        <= '0;
            cnt         <= '0;
            act_period  <= period;
            act_duty    <= duty;
            PWM_OUT     <= pol;
            PERIOD_TICK <= 1'b0;
        end else begin
            PWM_OUT     <= (cnt < act_duty) ^ pol;
            PERIOD_TICK <= wrap;
            if (tick) begin
                pcnt <= '0;
                if (wrap) begin
                    cnt        <= '0;
                    act_period <= period;
                    act_duty   <= duty;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                pcnt <= pcnt + CW'(1);
            end
        end
    end

    logic unused_inputs;
    assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

endmodule
`default_nettype wire

// File: tb/tb_axil_pwm_slave.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axil_pwm_slave
//  Purpose  : Directed self-checking bench for the AXI4-Lite PWM slave
//  Revision : 1.0 - initial release
// ============================================================================
module tb_axil_pwm_slave;
    logic        ACLK = 1'b0;
    logic        ARESETN = 1'b0;
    logic [3:0]  awaddr = '0, araddr = '0;
    logic [2:0]  awprot = '0, arprot = '0;
    logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b1, arvalid = 1'b0, rready = 1'b1;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        awready, wready, bvalid, arready, rvalid, pwm, ptick;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;

    int errors = 0;
    int checks = 0;

    axil_pwm_slave dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
        .PWM_OUT(pwm), .PERIOD_TICK(ptick)
    );

    always #5 ACLK = ~ACLK;

    // Waveform recorder: bit-pattern and length of each period, closed on PERIOD_TICK
    logic [31:0] hist = '0;
    logic [31:0] last_pat = '0;
    int          run_len = 0;
    int          last_len = 0;
    always @(negedge ACLK) begin
        hist <= {hist[30:0], pwm};
        if (ptick === 1'b1) begin
            last_pat <= {hist[30:0], pwm} & 32'h3FF;
            last_len <= run_len + 1;
            run_len  <= 0;
        end else begin
            run_len <= run_len + 1;
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
        int n = 0;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        do begin @(posedge ACLK); #1; n++; end while (!awready && n < 20);
        if (!awready) begin
            check("write_accept_timeout", 32'(awready), 32'd1);
            awvalid = 1'b0; wvalid = 1'b0;
            return;
        end
        @(posedge ACLK); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        check("bvalid_after_write", 32'(bvalid), 32'd1);
        check("bresp", 32'(bresp), 32'd0);
        @(posedge ACLK); #1;
    endtask

    task automatic axi_read(input logic [3:0] a, output logic [31:0] d);
        int n = 0;
        araddr = a; arvalid = 1'b1; rready = 1'b1;
        do begin @(posedge ACLK); #1; n++; end while (!arready && n < 20);
        if (!arready) begin
            check("read_accept_timeout", 32'(arready), 32'd1);
            arvalid = 1'b0;
            d = 'x;
            return;
        end
        @(posedge ACLK); #1;
        arvalid = 1'b0;
        check("rresp", 32'(rresp), 32'd0);
        d = rvalid ? rdata : 32'hxxxx_xxxx;
        @(posedge ACLK); #1;
    endtask

    task automatic wait_tick();
        int n = 0;
        do begin @(negedge ACLK); n++; end while (ptick !== 1'b1 && n < 400);
        if (ptick !== 1'b1) check("period_tick_timeout", 32'(ptick), 32'd1);
        #1;
    endtask

    typedef struct {
        logic [3:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp_rd;
    } reg_vec_t;

    reg_vec_t    vecs[7];
    logic [31:0] mdl[4];
    logic [31:0] rd;

    initial begin
        vecs[0] = '{4'h0, 32'h0000_0001, 4'hF, 32'h0000_0001};
        vecs[1] = '{4'h4, 32'h0000_0002, 4'hF, 32'h0000_0002};
        vecs[2] = '{4'h8, 32'h0000_0003, 4'hF, 32'h0000_0003};
        vecs[3] = '{4'hC, 32'h0000_0004, 4'hF, 32'h0000_0004};
        vecs[4] = '{4'hC, 32'hAABB_CCDD, 4'b0101, 32'h00BB_00DD};
        vecs[5] = '{4'h4, 32'hFFFF_FFFF, 4'b1000, 32'hFF00_0002};
        vecs[6] = '{4'h0, 32'hDEAD_BEE0, 4'hF, 32'hDEAD_BEE0};
        for (int i = 0; i < 4; i++) mdl[i] = '0;

        // Reset state
        repeat (3) @(posedge ACLK);
        #1;
        check("rst_awready", 32'(awready), 32'd0);
        check("rst_wready", 32'(wready), 32'd0);
        check("rst_bvalid", 32'(bvalid), 32'd0);
        check("rst_arready", 32'(arready), 32'd0);
        check("rst_rvalid", 32'(rvalid), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_pwm", 32'(pwm), 32'd0);
        check("rst_tick", 32'(ptick), 32'd0);
        @(negedge ACLK); ARESETN = 1'b1;
        @(posedge ACLK); #1;

        // Register table: write, immediate readback, then a full sweep
        for (int i = 0; i < 7; i++) begin
            axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb);
            axi_read(vecs[i].addr, rd);
            check($sformatf("readback_vec%0d", i), rd, vecs[i].exp_rd);
            mdl[vecs[i].addr[3:2]] = vecs[i].exp_rd;
        end
        for (int i = 0; i < 4; i++) begin
            axi_read(4'(i * 4), rd);
            check($sformatf("sweep_reg%0d", i), rd, mdl[i]);
        end

        // Read and write to DUTY accepted on the same edge: read sees the old value
        awaddr = 4'h8; wdata = 32'h77; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        araddr = 4'h8; arvalid = 1'b1;
        begin
            int n = 0;
            do begin @(posedge ACLK); #1; n++; end while (!awready && n < 20);
        end
        check("simul_arready", 32'(arready), 32'd1);
        @(posedge ACLK); #1;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        check("simul_rvalid", 32'(rvalid), 32'd1);
        check("simul_old_value", rdata, mdl[2]);
        mdl[2] = 32'h77;
        @(posedge ACLK); #1;
        axi_read(4'h8, rd);
        check("simul_new_value", rd, mdl[2]);

        // Disabled: PWM at POL (0), no ticks
        axi_write(4'h4, 32'd9, 4'hF);
        axi_write(4'h8, 32'd3, 4'hF);
        axi_write(4'hC, 32'd0, 4'hF);
        begin
            int bad = 0;
            repeat (12) begin @(posedge ACLK); #1; if (pwm !== 1'b0 || ptick !== 1'b0) bad++; end
            check("disabled_idle", 32'(bad), 32'd0);
        end

        // PERIOD=9 DUTY=3: 3 high, 7 low, 10-cycle period
        axi_write(4'h0, 32'h1, 4'hF);
        wait_tick(); wait_tick();
        check("pwm_base_pattern", last_pat, 32'h380);
        check("pwm_base_len", 32'(last_len), 32'd10);

        // DUTY change mid-period is deferred to the next wrap
        wait_tick();
        axi_write(4'h8, 32'd5, 4'hF);
        wait_tick();
        check("shadow_current", last_pat, 32'h380);
        wait_tick();
        check("shadow_next", last_pat, 32'h3E0);

        // Polarity and the duty extremes
        axi_write(4'h8, 32'd3, 4'hF);
        axi_write(4'h0, 32'h3, 4'hF);
        wait_tick(); wait_tick();
        check("pol_pattern", last_pat, 32'h07F);
        axi_write(4'h8, 32'd0, 4'hF);
        wait_tick(); wait_tick();
        check("duty0_const_pol", last_pat, 32'h3FF);
        axi_write(4'h8, 32'd20, 4'hF);
        wait_tick(); wait_tick();
        check("duty_gt_period", last_pat, 32'h000);
        check("duty_gt_period_len", 32'(last_len), 32'd10);

        // Prescaler: PERIOD=4, PRESCALE=1 -> (4+1)*(1+1)=10 cycles, DUTY=2 -> 4 high
        axi_write(4'h0, 32'h1, 4'hF);
        axi_write(4'h8, 32'd2, 4'hF);
        axi_write(4'h4, 32'd4, 4'hF);
        axi_write(4'hC, 32'd1, 4'hF);
        wait_tick(); wait_tick(); wait_tick();
        check("prescale_pattern", last_pat, 32'h3C0);
        check("prescale_len", 32'(last_len), 32'd10);

        // EN=0 with POL=1 parks the output high
        axi_write(4'h0, 32'h2, 4'hF);
        repeat (2) @(posedge ACLK);
        #1;
        check("disabled_pol", 32'(pwm), 32'd1);

        // AW without W is never accepted
        awaddr = 4'h4; wdata = 32'h1234; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b0; bready = 1'b0;
        begin
            int seen = 0;
            repeat (5) begin @(posedge ACLK); #1; if (awready || wready) seen++; end
            check("aw_alone_no_ready", 32'(seen), 32'd0);
        end
        wvalid = 1'b1;
        begin
            int nacc = 0;
            for (int i = 0; i < 6; i++) begin
                @(posedge ACLK); #1;
                if (awready) nacc++;
                else if (nacc > 0) begin awvalid = 1'b0; wvalid = 1'b0; end
            end
            check("single_accept", 32'(nacc), 32'd1);
        end
        begin
            int held = 0;
            repeat (4) begin @(posedge ACLK); #1; if (bvalid) held++; end
            check("bvalid_held", 32'(held), 32'd4);
        end

        // Asynchronous reset mid-response
        @(posedge ACLK); #2;
        ARESETN = 1'b0;
        #1;
        check("async_rst_bvalid", 32'(bvalid), 32'd0);
        check("async_rst_pwm", 32'(pwm), 32'd0);
        repeat (2) @(posedge ACLK);
        @(negedge ACLK); ARESETN = 1'b1; bready = 1'b1;
        @(posedge ACLK); #1;
        axi_read(4'h0, rd);
        check("post_rst_ctrl", rd, 32'd0);
        axi_read(4'h4, rd);
        check("post_rst_period", rd, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
`default_nettype wire
